// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a parallel word over valid/ready and sends
// preamble, then payload MSB-first, then an idle gap, one bit per bit_en strobe.
module seq_frame_tx #(
    parameter int               DATA_W   = 8,
    parameter int               PRE_W    = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b1010,
    parameter int               GAP      = 2,
    parameter logic             IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_AB  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_LEN = (MAX_AB > GAP) ? MAX_AB : GAP;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [DATA_W-1:0]   r_sreg, w_sreg;
    logic                r_dout, w_dout;
    logic                r_dout_valid, w_dout_valid;
    logic                r_frame_done, w_frame_done;
    logic                r_din_ready, w_din_ready;
    logic                w_pre_bit;

    // Preamble bit selected by counter; a loop avoids index-width mismatches.
    always_comb begin
        w_pre_bit = IDLE_BIT;
        for (int i = 0; i < PRE_W; i++) begin
            if (int'(r_cnt) == PRE_W - 1 - i) begin
                w_pre_bit = PREAMBLE[i];
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_sreg       = r_sreg;
        w_dout       = r_dout;
        w_dout_valid = r_dout_valid;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dout       = IDLE_BIT;
                w_dout_valid = 1'b0;
                if (din_valid) begin
                    w_sreg  = din;
                    w_cnt   = '0;
                    w_state = S_PRE;
                end
            end
            S_PRE: begin
                if (bit_en) begin
                    w_dout       = w_pre_bit;
                    w_dout_valid = 1'b1;
                    w_cnt        = r_cnt + CNT_W'(1);
                    if (int'(r_cnt) == PRE_W - 1) begin
                        w_cnt   = '0;
                        w_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    w_dout       = r_sreg[DATA_W-1];
                    w_sreg       = r_sreg << 1;
                    w_dout_valid = 1'b1;
                    w_cnt        = r_cnt + CNT_W'(1);
                    if (int'(r_cnt) == DATA_W - 1) begin
                        w_cnt        = '0;
                        w_state      = S_GAP;
                        w_frame_done = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (bit_en) begin
                    w_dout       = IDLE_BIT;
                    w_dout_valid = 1'b0;
                    w_cnt        = r_cnt + CNT_W'(1);
                    if (int'(r_cnt) == GAP - 1) begin
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
        w_din_ready = (w_state == S_IDLE);
    end

    // Reset abandons any partial frame without a completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sreg       <= '0;
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_din_ready  <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_sreg       <= w_sreg;
            r_dout       <= w_dout;
            r_dout_valid <= w_dout_valid;
            r_frame_done <= w_frame_done;
            r_din_ready  <= w_din_ready;
        end
    end

    assign din_ready  = r_din_ready;
    assign busy       = (r_state != S_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: a frame-sequence model compared every
// cycle, plus literal frame contents, gap spacing and a 1010 loopback detector.
module tb_seq_frame_tx;

    localparam int         DATA_W   = 8;
    localparam int         PRE_W    = 4;
    localparam int         GAP      = 2;
    localparam logic [3:0] PREAMBLE = 4'b1010;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bit_en = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              dout;
    logic              dout_valid;
    logic              busy;
    logic              frame_done;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;
    int enMode = 0;
    int cyc = 0;
    bit enAtEdge = 1'b0;

    // Model: the whole frame as a list of line symbols, consumed one per strobe.
    bit mReady = 1'b1;
    bit eDout = 1'b0;
    bit eValid = 1'b0;
    bit eDone = 1'b0;
    bit seqBit[$];
    bit seqVal[$];
    int mPos = 0;

    bit logBits[$];
    int logCyc[$];
    int doneAt[$];
    logic [3:0] hist = 4'b0000;
    int detHits = 0;
    int detAt = 0;

    seq_frame_tx #(
        .DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(PREAMBLE), .GAP(GAP), .IDLE_BIT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mReady = 1'b1;
            eDout  = 1'b0;
            eValid = 1'b0;
            eDone  = 1'b0;
            mPos   = 0;
        end else begin
            eDone = 1'b0;
            if (mReady) begin
                if (din_valid) begin
                    seqBit.delete();
                    seqVal.delete();
                    for (int i = PRE_W - 1; i >= 0; i--) begin
                        seqBit.push_back(PREAMBLE[i]);
                        seqVal.push_back(1'b1);
                    end
                    for (int i = DATA_W - 1; i >= 0; i--) begin
                        seqBit.push_back(din[i]);
                        seqVal.push_back(1'b1);
                    end
                    for (int i = 0; i < GAP; i++) begin
                        seqBit.push_back(1'b0);
                        seqVal.push_back(1'b0);
                    end
                    mPos   = 0;
                    mReady = 1'b0;
                end
            end else if (bit_en) begin
                eDout  = seqBit[mPos];
                eValid = seqVal[mPos];
                eDone  = (mPos == PRE_W + DATA_W - 1);
                mPos++;
                if (mPos == seqBit.size()) mReady = 1'b1;
            end
        end
        enAtEdge = bit_en;
        cyc++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("dout", int'(dout), int'(eDout));
            checkOutput("dout_valid", int'(dout_valid), int'(eValid));
            checkOutput("din_ready", int'(din_ready), int'(mReady));
            checkOutput("busy", int'(busy), int'(!mReady));
            checkOutput("frame_done", int'(frame_done), int'(eDone));
        end
    end

    // Frame-bit log and a behavioural 1010 Mealy detector watching the line.
    always @(negedge clk) begin
        if (checkOn) begin
            if (dout_valid && enAtEdge) begin
                logBits.push_back(dout);
                logCyc.push_back(cyc);
            end
            if (frame_done) doneAt.push_back(logBits.size());
            if (enAtEdge) begin
                hist = {hist[2:0], dout};
                if (hist == 4'b1010) begin
                    detHits++;
                    detAt = logBits.size();
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bit_en = (enMode == 0) || (cyc % 3 == 0);
        end
    endtask

    task automatic clearLog();
        logBits.delete();
        logCyc.delete();
        doneAt.delete();
        hist    = 4'b0000;
        detHits = 0;
        detAt   = 0;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word);
        din       = word;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        din       = ~word;
    endtask

    function automatic int packLog();
        int v = 0;
        foreach (logBits[i]) v = (v << 1) | int'(logBits[i]);
        return v;
    endfunction

    task automatic checkFrame(input string name, input int expBits, input int nBits, input int nDone);
        checkOutput({name, " length"}, logBits.size(), nBits);
        checkOutput({name, " bits"}, packLog(), expBits);
        checkOutput({name, " done count"}, doneAt.size(), nDone);
        if (doneAt.size() > 0) checkOutput({name, " done position"}, doneAt[doneAt.size()-1], nBits);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        checkOn = 1'b1;
        clearLog();
        step(10);
        checkOutput("idle frame bits", logBits.size(), 0);
        checkOutput("idle done pulses", doneAt.size(), 0);

        clearLog();
        applyStimulus(8'hA5);
        step(20);
        checkFrame("A5", 32'hAA5, 12, 1);

        clearLog();
        din       = 8'hFF;
        din_valid = 1'b1;
        step(1);
        din = 8'h00;
        step(15);
        din_valid = 1'b0;
        step(20);
        checkFrame("FF_00", 32'hAFFA00, 24, 2);
        if (doneAt.size() == 2) checkOutput("FF first done", doneAt[0], 12);
        if (logCyc.size() == 24) checkOutput("inter-frame spacing", logCyc[12] - logCyc[11], GAP + 2);

        enMode = 1;
        clearLog();
        applyStimulus(8'h3C);
        step(60);
        checkFrame("3C slow", 32'hA3C, 12, 1);
        if (logCyc.size() == 12) checkOutput("3C bit period", logCyc[11] - logCyc[0], 33);
        enMode = 0;
        step(2);

        clearLog();
        applyStimulus(8'h5A);
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("abort bits sent", logBits.size(), 10);
        checkOutput("abort done pulses", doneAt.size(), 0);
        @(negedge clk);
        checkOutput("abort dout", int'(dout), 0);
        checkOutput("abort dout_valid", int'(dout_valid), 0);
        checkOutput("abort din_ready", int'(din_ready), 1);
        step(1);
        clearLog();
        applyStimulus(8'h81);
        step(20);
        checkFrame("81 after abort", 32'hA81, 12, 1);

        clearLog();
        applyStimulus(8'h00);
        step(20);
        checkFrame("00 loopback", 32'hA00, 12, 1);
        checkOutput("detector hits", detHits, 1);
        checkOutput("detector position", detAt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
